// File: rtl/fetch_stage_if.sv
// fetch_stage_if
//   Bundles the fetch stage's control inputs, instruction-memory bus,
//   IF/ID register outputs and performance counters.
//   master : the fetch stage (drives imem_addr, id_*, perf_*)
//   slave  : the surrounding core / memory (drives stall, redirect,
//            redirect_target, imem_data)
interface fetch_stage_if;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_target;
  logic [31:0] imem_addr;
  logic [31:0] imem_data;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus8;
  logic [5:0]  id_opcode;
  logic [4:0]  id_rs1;
  logic [4:0]  id_rs2;
  logic [4:0]  id_rd;
  logic [15:0] id_immediate;
  logic [5:0]  id_function;
  logic [31:0] perf_fetched;
  logic [31:0] perf_stalls;
  logic [31:0] perf_flushes;

  modport master (
    input  stall, redirect, redirect_target, imem_data,
    output imem_addr, id_valid, id_instr, id_pc, id_pc_plus8,
           id_opcode, id_rs1, id_rs2, id_rd, id_immediate, id_function,
           perf_fetched, perf_stalls, perf_flushes
  );

  modport slave (
    output stall, redirect, redirect_target, imem_data,
    input  imem_addr, id_valid, id_instr, id_pc, id_pc_plus8,
           id_opcode, id_rs1, id_rs2, id_rd, id_immediate, id_function,
           perf_fetched, perf_stalls, perf_flushes
  );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage
//   IF stage and IF/ID pipeline register of the pipelined DLX core. Holds the
//   PC, drives the instruction-memory address and captures the fetched word,
//   its PC and the PC+8 link value. Honours stall and redirect (redirect wins).
// Ports
//   clk    : core clock, rising-edge
//   reset  : asynchronous, active-high
//   bus    : fetch_stage_if.master (control in, imem bus, IF/ID out, perf out)
// Parameters
//   RESET_PC  : PC loaded on reset
//   NOP_INSTR : instruction word held in IF/ID while it carries a bubble
// Configuration
//   FETCH_PERF_EN : when defined, builds the fetched/stall/flush counters;
//                   otherwise perf_* are tied to zero and no flops exist.
// Field slices use DLX big-endian numbering: DLX bit i is bit (31-i) here,
// so the opcode (DLX [0:5]) is instr[31:26].
module fetch_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         reset,
  fetch_stage_if.master bus
);

  logic [31:0] pc;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic [31:0] id_pc_plus8;
  logic        id_valid;

  // Wrapping 32-bit arithmetic is intended: FFFF_FFFC + 4 = 0.
  logic [31:0] pc_plus4;
  logic [31:0] pc_plus8;
  assign pc_plus4 = pc + 32'd4;
  assign pc_plus8 = pc + 32'd8;

  // PC and IF/ID register: redirect, then stall, then normal advance.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc          <= RESET_PC;
      id_valid    <= 1'b0;
      id_instr    <= NOP_INSTR;
      id_pc       <= 32'h0000_0000;
      id_pc_plus8 <= 32'h0000_0000;
    end else if (bus.redirect) begin
      // Word alignment: the two low target bits are discarded.
      pc       <= bus.redirect_target & ~32'h0000_0003;
      id_valid <= 1'b0;
      id_instr <= NOP_INSTR;
    end else if (!bus.stall) begin
      pc          <= pc_plus4;
      id_instr    <= bus.imem_data;
      id_pc       <= pc;
      id_pc_plus8 <= pc_plus8;
      id_valid    <= 1'b1;
    end
  end

  assign bus.imem_addr    = pc;
  assign bus.id_valid     = id_valid;
  assign bus.id_instr     = id_instr;
  assign bus.id_pc        = id_pc;
  assign bus.id_pc_plus8  = id_pc_plus8;
  assign bus.id_opcode    = id_instr[31:26];
  assign bus.id_rs1       = id_instr[25:21];
  assign bus.id_rs2       = id_instr[20:16];
  assign bus.id_rd        = id_instr[15:11];
  assign bus.id_immediate = id_instr[15:0];
  assign bus.id_function  = id_instr[5:0];

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched;
  logic [31:0] perf_stalls;
  logic [31:0] perf_flushes;

  // Event counters, one per edge path; all wrap at 2^32.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_fetched <= 32'h0000_0000;
      perf_stalls  <= 32'h0000_0000;
      perf_flushes <= 32'h0000_0000;
    end else if (bus.redirect) begin
      perf_flushes <= perf_flushes + 32'd1;
    end else if (bus.stall) begin
      perf_stalls  <= perf_stalls + 32'd1;
    end else begin
      perf_fetched <= perf_fetched + 32'd1;
    end
  end

  assign bus.perf_fetched = perf_fetched;
  assign bus.perf_stalls  = perf_stalls;
  assign bus.perf_flushes = perf_flushes;
`else
  assign bus.perf_fetched = 32'h0000_0000;
  assign bus.perf_stalls  = 32'h0000_0000;
  assign bus.perf_flushes = 32'h0000_0000;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage
//   Directed bench for fetch_stage. DUT a uses RESET_PC=0 and a non-zero
//   NOP_INSTR; DUT b uses RESET_PC=FFFF_FFF8 to exercise PC wrap.
module tb_fetch_stage;
  localparam logic [31:0] NOP_A = 32'hFC00_0001;

  logic clk = 1'b0;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  fetch_stage_if ifa ();
  fetch_stage_if ifb ();

  fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP_A)) dut_a (
    .clk(clk), .reset(reset), .bus(ifa.master));
  fetch_stage #(.RESET_PC(32'hFFFF_FFF8), .NOP_INSTR(32'h0000_0000)) dut_b (
    .clk(clk), .reset(reset), .bus(ifb.master));

  // Instruction memory model: a distinctive word per address, plus the
  // load word used for the field-decode check at 0x10.
  function automatic logic [31:0] mem_word(input logic [31:0] addr);
    if (addr == 32'h0000_0010) return 32'h8C22_0010;
    return {16'h1000, addr[15:0]};
  endfunction

  assign ifa.imem_data = mem_word(ifa.imem_addr);
  assign ifb.imem_data = mem_word(ifb.imem_addr);

  task automatic check_val(input string tag, input logic [31:0] got,
                           input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    ifa.stall = 1'b0; ifa.redirect = 1'b0; ifa.redirect_target = 32'h0;
    ifb.stall = 1'b0; ifb.redirect = 1'b0; ifb.redirect_target = 32'h0;
    repeat (3) tick();

    // Reset state
    check_val("rst_addr",   ifa.imem_addr,    32'h0);
    check_val("rst_valid",  ifa.id_valid,     32'h0);
    check_val("rst_instr",  ifa.id_instr,     NOP_A);
    check_val("rst_pc",     ifa.id_pc,        32'h0);
    check_val("rst_pc8",    ifa.id_pc_plus8,  32'h0);
    check_val("rst_perf",   ifa.perf_fetched | ifa.perf_stalls | ifa.perf_flushes, 32'h0);
    check_val("rst_b_addr", ifb.imem_addr,    32'hFFFF_FFF8);

    // Sequential fetch; DUT b wraps through zero
    reset = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check_val("seq_addr",  ifa.imem_addr,   32'(4 * (k + 1)));
      check_val("seq_pc",    ifa.id_pc,       32'(4 * k));
      check_val("seq_valid", ifa.id_valid,    32'h1);
      check_val("seq_instr", ifa.id_instr,    mem_word(32'(4 * k)));
      check_val("seq_pc8",   ifa.id_pc_plus8, 32'(4 * k + 8));
      if (k < 3) begin
        check_val("wrap_pc",   ifb.id_pc,     32'hFFFF_FFF8 + 32'(4 * k));
        check_val("wrap_addr", ifb.imem_addr, 32'hFFFF_FFFC + 32'(4 * k));
      end
      if (k == 1) check_val("wrap_pc8", ifb.id_pc_plus8, 32'h0000_0004);
    end

    // Field decode of 8C22_0010 fetched at 0x10
    tick();
    check_val("dec_instr", ifa.id_instr,     32'h8C22_0010);
    check_val("dec_op",    ifa.id_opcode,    32'h23);
    check_val("dec_rs1",   ifa.id_rs1,       32'h1);
    check_val("dec_rs2",   ifa.id_rs2,       32'h2);
    check_val("dec_rd",    ifa.id_rd,        32'h0);
    check_val("dec_imm",   ifa.id_immediate, 32'h0010);
    check_val("dec_fn",    ifa.id_function,  32'h10);
    check_val("dec_pc8",   ifa.id_pc_plus8,  32'h18);

    repeat (3) tick();
    check_val("pre_stall_addr", ifa.imem_addr, 32'h20);
    check_val("pre_stall_pc",   ifa.id_pc,     32'h1C);

    // Two stall cycles at pc=0x20
    ifa.stall = 1'b1;
    repeat (2) tick();
    check_val("stall_addr",  ifa.imem_addr, 32'h20);
    check_val("stall_pc",    ifa.id_pc,     32'h1C);
    check_val("stall_instr", ifa.id_instr,  mem_word(32'h1C));
    check_val("stall_valid", ifa.id_valid,  32'h1);
    ifa.stall = 1'b0;
    tick();
    check_val("resume_pc",    ifa.id_pc,     32'h20);
    check_val("resume_instr", ifa.id_instr,  mem_word(32'h20));
    check_val("resume_addr",  ifa.imem_addr, 32'h24);

    // Redirect to 0x103 together with stall: redirect wins, target aligned
    ifa.redirect = 1'b1; ifa.redirect_target = 32'h0000_0103; ifa.stall = 1'b1;
    tick();
    check_val("redir_addr",  ifa.imem_addr,   32'h100);
    check_val("redir_valid", ifa.id_valid,    32'h0);
    check_val("redir_instr", ifa.id_instr,    NOP_A);
    check_val("redir_pc",    ifa.id_pc,       32'h20);
    check_val("redir_pc8",   ifa.id_pc_plus8, 32'h28);
    ifa.redirect = 1'b0; ifa.stall = 1'b0;
    tick();
    check_val("post_redir_pc",    ifa.id_pc,       32'h100);
    check_val("post_redir_valid", ifa.id_valid,    32'h1);
    check_val("post_redir_pc8",   ifa.id_pc_plus8, 32'h108);

    // One more stall and a plain redirect: totals 10 fetches/3 stalls/2 flushes
    ifa.stall = 1'b1;
    tick();
    ifa.stall = 1'b0; ifa.redirect = 1'b1; ifa.redirect_target = 32'h0000_0202;
    tick();
    ifa.redirect = 1'b0;
    check_val("redir2_addr", ifa.imem_addr, 32'h200);
    check_val("redir2_pc",   ifa.id_pc,     32'h100);
`ifdef FETCH_PERF_EN
    check_val("perf_fetched", ifa.perf_fetched, 32'd10);
    check_val("perf_stalls",  ifa.perf_stalls,  32'd3);
    check_val("perf_flushes", ifa.perf_flushes, 32'd2);
`else
    check_val("perf_fetched", ifa.perf_fetched, 32'd0);
    check_val("perf_stalls",  ifa.perf_stalls,  32'd0);
    check_val("perf_flushes", ifa.perf_flushes, 32'd0);
`endif

    // Asynchronous reset between clock edges
    #2;
    reset = 1'b1;
    #1;
    check_val("async_addr",  ifa.imem_addr,    32'h0);
    check_val("async_valid", ifa.id_valid,     32'h0);
    check_val("async_instr", ifa.id_instr,     NOP_A);
    check_val("async_perf",  ifa.perf_fetched | ifa.perf_stalls | ifa.perf_flushes, 32'h0);
    check_val("async_b",     ifb.imem_addr,    32'hFFFF_FFF8);
    repeat (2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
